prng_stream: RTL and testbench

- Parametrised successor to the fixed 16-bit pseudo-random number generator.
- Galois LFSR of configurable width and polynomial, with runtime reseeding and a configurable number of LFSR steps per emitted word (decorrelation stride).
- Emits words over a valid/ready handshake, so it can feed stimulus channels or recorders that apply backpressure.

---
 rtl/prng_stream_if.sv | 36 +++
 rtl/prng_stream.sv | 103 ++++++++++
 tb/tb_prng_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prng_stream_if.sv
// prng_stream_if: control and valid/ready stream bundle for prng_stream.
//   en_i          step enable (0 freezes LFSR stepping while filling)
//   seed_valid_i  load seed_i this cycle
//   seed_i        new LFSR seed (zero is replaced by 1)
//   num_o         emitted random word, registered
//   valid_o       num_o holds an unconsumed word
//   ready_i       consumer accepts num_o
// The master modport is the generator side; the slave modport is the consumer side.
interface prng_stream_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en_i;
  logic             seed_valid_i;
  logic [WIDTH-1:0] seed_i;
  logic [WIDTH-1:0] num_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    input  en_i,
    input  seed_valid_i,
    input  seed_i,
    input  ready_i,
    output num_o,
    output valid_o
  );

  modport slave (
    output en_i,
    output seed_valid_i,
    output seed_i,
    output ready_i,
    input  num_o,
    input  valid_o
  );
endinterface

// File: rtl/prng_stream.sv
// prng_stream: Galois LFSR pseudo-random word source with runtime reseeding, a configurable
// number of LFSR steps per emitted word, and a valid/ready output handshake.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous reset, active-low
//   prng_bus  prng_stream_if.master (en_i, seed_valid_i, seed_i, ready_i in; num_o, valid_o out)
//   count_o   32-bit saturating accepted-word counter, present only when PRNG_STATS_EN is
//             defined (cleared by reset only, not by seed load)
// Build option: define PRNG_STATS_EN to add count_o.
module prng_stream #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      STEPS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  prng_stream_if.master        prng_bus
`ifdef PRNG_STATS_EN
  ,
  output logic [31:0]          count_o
`endif
);

  // Zero is a lock-up state for the LFSR, so it is never loaded.
  localparam logic [WIDTH-1:0] SeedInit = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [7:0]       LastCnt  = 8'(STEPS - 1);

  typedef enum logic {StFill, StHold} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_num;
  logic             r_valid;
  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_seed_safe;

  always_comb begin
    w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    w_seed_safe = (prng_bus.seed_i == '0) ? WIDTH'(1) : prng_bus.seed_i;
  end

  // Reset beats seed load, which beats stepping and the handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= StFill;
      r_lfsr  <= SeedInit;
      r_cnt   <= '0;
      r_num   <= '0;
      r_valid <= 1'b0;
    end else if (prng_bus.seed_valid_i) begin
      // A pending word is dropped; num_o keeps its stale value.
      r_state <= StFill;
      r_lfsr  <= w_seed_safe;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (prng_bus.en_i) begin
            r_lfsr <= w_lfsr_next;
            if (r_cnt == LastCnt) begin
              r_cnt   <= '0;
              r_num   <= w_lfsr_next;
              r_valid <= 1'b1;
              r_state <= StHold;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        StHold: begin
          // LFSR is frozen here regardless of en_i.
          if (prng_bus.ready_i) begin
            r_valid <= 1'b0;
            r_state <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign prng_bus.num_o   = r_num;
  assign prng_bus.valid_o = r_valid;

`ifdef PRNG_STATS_EN
  logic [31:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (r_valid && prng_bus.ready_i && !prng_bus.seed_valid_i &&
                 (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count_o = r_count;
`endif

endmodule

// File: tb/tb_prng_stream.sv
// tb_prng_stream: drives two prng_stream instances (STEPS=1 and STEPS=4) from shared inputs,
// checks them every cycle against a behavioural model, and pins the model with literal words.
// Define PRNG_STATS_EN to also exercise count_o.
module tb_prng_stream;
  localparam int unsigned W = 16;
  localparam logic [15:0] Taps = 16'hB400;

  logic clk;
  logic rst;
  logic en;
  logic ready;
  logic seed_valid;
  logic [15:0] seed;

  int total;
  int bad;

  prng_stream_if #(.WIDTH(W)) bus_a ();
  prng_stream_if #(.WIDTH(W)) bus_b ();

  assign bus_a.en_i = en;
  assign bus_a.seed_valid_i = seed_valid;
  assign bus_a.seed_i = seed;
  assign bus_a.ready_i = ready;
  assign bus_b.en_i = en;
  assign bus_b.seed_valid_i = seed_valid;
  assign bus_b.seed_i = seed;
  assign bus_b.ready_i = ready;

  logic [31:0] cnt_a;
  logic [31:0] cnt_b;

`ifdef PRNG_STATS_EN
  prng_stream #(.WIDTH(W), .TAPS(Taps), .SEED(16'd1), .STEPS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .prng_bus(bus_a), .count_o(cnt_a)
  );
  prng_stream #(.WIDTH(W), .TAPS(Taps), .SEED(16'd1), .STEPS(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .prng_bus(bus_b), .count_o(cnt_b)
  );
`else
  prng_stream #(.WIDTH(W), .TAPS(Taps), .SEED(16'd1), .STEPS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .prng_bus(bus_a)
  );
  prng_stream #(.WIDTH(W), .TAPS(Taps), .SEED(16'd1), .STEPS(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .prng_bus(bus_b)
  );
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  logic [15:0] d_num[2];
  logic        d_valid[2];
  logic [31:0] d_cnt[2];
  assign d_num[0] = bus_a.num_o;
  assign d_num[1] = bus_b.num_o;
  assign d_valid[0] = bus_a.valid_o;
  assign d_valid[1] = bus_b.valid_o;
  assign d_cnt[0] = cnt_a;
  assign d_cnt[1] = cnt_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a word is the LFSR value after every STEPS enabled steps; it is
  // offered until taken, reseeding drops it, acceptances are tallied.
  int          m_steps[2] = '{1, 4};
  logic [15:0] m_lfsr[2];
  int          m_done[2];
  bit          m_have[2];
  logic [15:0] m_num[2];
  logic [31:0] m_cnt[2];

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ Taps) : (x >> 1);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_lfsr[d] = 16'd1;
        m_done[d] = 0;
        m_have[d] = 0;
        m_num[d]  = 16'd0;
        m_cnt[d]  = 32'd0;
      end else if (seed_valid) begin
        m_lfsr[d] = (seed == 16'd0) ? 16'd1 : seed;
        m_done[d] = 0;
        m_have[d] = 0;
      end else if (m_have[d]) begin
        if (ready) begin
          m_have[d] = 0;
          if (m_cnt[d] != 32'hFFFF_FFFF) m_cnt[d] = m_cnt[d] + 32'd1;
        end
      end else if (en) begin
        m_lfsr[d] = lfsr_step(m_lfsr[d]);
        m_done[d] = m_done[d] + 1;
        if (m_done[d] == m_steps[d]) begin
          m_num[d]  = m_lfsr[d];
          m_have[d] = 1;
          m_done[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check(d == 0 ? "s1_num" : "s4_num", 32'(d_num[d]), 32'(m_num[d]));
      check(d == 0 ? "s1_valid" : "s4_valid", 32'(d_valid[d]), 32'(m_have[d]));
`ifdef PRNG_STATS_EN
      check(d == 0 ? "s1_count" : "s4_count", d_cnt[d], m_cnt[d]);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] exp_words[3] = '{16'h5A00, 16'h2D00, 16'h1680};
  logic [31:0] saved_cnt;
  int acc;
  bit seen;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    en = 1'b0;
    ready = 1'b0;
    seed_valid = 1'b0;
    seed = 16'd0;

    // Reset state
    cyc(2);
    check("rst_valid_a", 32'(d_valid[0]), 32'd0);
    check("rst_num_a", 32'(d_num[0]), 32'd0);
    check("rst_valid_b", 32'(d_valid[1]), 32'd0);

    // First words: STEPS=1 after one cycle, STEPS=4 after four
    rst = 1'b1;
    en = 1'b1;
    cyc(1);
    check("first_a_valid", 32'(d_valid[0]), 32'd1);
    check("first_a_num", 32'(d_num[0]), 32'hB400);
    cyc(2);
    check("b_not_yet", 32'(d_valid[1]), 32'd0);
    cyc(1);
    check("first_b_valid", 32'(d_valid[1]), 32'd1);
    check("first_b_num", 32'(d_num[1]), 32'h1680);
    cyc(10);
    check("b_held_num", 32'(d_num[1]), 32'h1680);
    check("b_held_valid", 32'(d_valid[1]), 32'd1);

    // Successive STEPS=1 words under ready=1
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      seen = 0;
      for (int t = 0; t < 5 && !seen; t++) begin
        cyc(1);
        if (d_valid[0]) seen = 1;
      end
      check("seq_a_seen", 32'(seen), 32'd1);
      check("seq_a_num", 32'(d_num[0]), 32'(exp_words[k]));
    end

    // Seed load of zero in HOLD with ready=1 drops the word uncounted
    saved_cnt = d_cnt[0];
    seed_valid = 1'b1;
    seed = 16'd0;
    cyc(1);
    check("seed_drop_valid", 32'(d_valid[0]), 32'd0);
    check("seed_keep_num", 32'(d_num[0]), 32'h1680);
`ifdef PRNG_STATS_EN
    check("seed_no_count", d_cnt[0], saved_cnt);
`endif
    seed_valid = 1'b0;
    ready = 1'b0;
    cyc(1);
    check("reseed_a_num", 32'(d_num[0]), 32'hB400);
    cyc(1);
    // STEPS=4 instance has taken 2 steps; freeze it
    en = 1'b0;
    cyc(5);
    check("frozen_b_valid", 32'(d_valid[1]), 32'd0);
    en = 1'b1;
    cyc(1);
    check("resume_b_valid", 32'(d_valid[1]), 32'd0);
    cyc(1);
    check("resume_b_valid2", 32'(d_valid[1]), 32'd1);
    check("resume_b_num", 32'(d_num[1]), 32'h1680);

    // Reset while holding after three accepted words
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    ready = 1'b1;
    acc = 0;
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      cyc(1);
      if (d_valid[0]) begin
        if (acc == 3) begin
          ready = 1'b0;
          seen = 1;
        end else begin
          acc++;
        end
      end
    end
    check("hold3_seen", 32'(seen), 32'd1);
    cyc(1);
`ifdef PRNG_STATS_EN
    check("hold3_count", d_cnt[0], 32'd3);
`endif
    rst = 1'b0;
    cyc(1);
    check("rst_hold_valid", 32'(d_valid[0]), 32'd0);
    check("rst_hold_num", 32'(d_num[0]), 32'd0);
`ifdef PRNG_STATS_EN
    check("rst_hold_count", d_cnt[0], 32'd0);
`endif
    rst = 1'b1;
    cyc(1);
    check("restart_num", 32'(d_num[0]), 32'hB400);

    // 200 cycles at full handshake: 100 words for STEPS=1, 40 for STEPS=4
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    ready = 1'b1;
    en = 1'b1;
    cyc(200);
`ifdef PRNG_STATS_EN
    check("count100_a", d_cnt[0], 32'd100);
    check("count40_b", d_cnt[1], 32'd40);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 9) < 8);
      ready = ($urandom_range(0, 1) == 1);
      seed_valid = ($urandom_range(0, 29) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
